// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
//   Shared definitions for the successive-approximation search controller:
//   the default operand width and the controller state encoding.
// -----------------------------------------------------------------------------
package sar_pkg;

  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } sar_state_e;

endpackage : sar_pkg

// File: rtl/sar_search_ctrl_bit_decide.sv
// -----------------------------------------------------------------------------
// sar_bit_decide
//   Combinational per-step decision of the successive-approximation search.
//   Given the current trial word, the bit index under test and the comparator
//   response, it produces the next trial word and classifies the response.
//
// Ports
//   trial      in   WIDTH  current probe value
//   idx        in   IW     bit currently being decided
//   cmp_equal  in   1      comparator: a == trial
//   cmp_a_big  in   1      comparator: a > trial
//   cmp_b_big  in   1      comparator: trial > a
//   next_trial out  WIDTH  trial with bit idx decided and bit idx-1 set
//   last       out  1      idx is the LSB; no further bit to try
//   hit        out  1      valid one-hot response reporting equal
//   bad        out  1      response is not one-hot
// -----------------------------------------------------------------------------
module sar_bit_decide #(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] trial,
  input  logic [IW-1:0]    idx,
  input  logic             cmp_equal,
  input  logic             cmp_a_big,
  input  logic             cmp_b_big,
  output logic [WIDTH-1:0] next_trial,
  output logic             last,
  output logic             hit,
  output logic             bad
);

  logic w_onehot;

  assign w_onehot = ( cmp_equal & ~cmp_a_big & ~cmp_b_big) |
                    (~cmp_equal &  cmp_a_big & ~cmp_b_big) |
                    (~cmp_equal & ~cmp_a_big &  cmp_b_big);

  assign last = (idx == '0);
  assign hit  = w_onehot & cmp_equal;
  assign bad  = ~w_onehot;

  // Only bit idx (decided) and bit idx-1 (next guess) ever change; the
  // decrement index is only formed when idx is non-zero, so it never wraps.
  always_comb begin
    next_trial = trial;
    if (cmp_b_big) begin
      next_trial[idx] = 1'b0;
    end
    if (idx != '0) begin
      next_trial[idx - 1'b1] = 1'b1;
    end
  end

endmodule : sar_bit_decide

// File: rtl/sar_search_ctrl.sv
// -----------------------------------------------------------------------------
// sar_search_ctrl
//   Successive-approximation search initiator. Drives the b operand (probe)
//   of an external magnitude comparator and recovers the hidden a operand
//   MSB-first, one probe per clock, with early exit when equal is reported.
//
// Handshake: start is sampled only in IDLE; busy is high while probing
//   (SEARCH/VERIFY); done pulses for exactly one cycle when result, found and
//   error are valid, and those three hold until the next accepted start.
//   start seen while busy or during the done cycle is dropped.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      search request
//   cmp_equal  in   1      comparator: a == probe
//   cmp_a_big  in   1      comparator: a > probe
//   cmp_b_big  in   1      comparator: probe > a
//   probe      out  WIDTH  b operand to the comparator
//   busy       out  1      search in progress
//   done       out  1      one-cycle completion pulse
//   result     out  WIDTH  recovered value
//   found      out  1      final compare reported equal
//   error      out  1      a non-one-hot comparator response was seen
//   dbg_state  out  2      current FSM state
// -----------------------------------------------------------------------------
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_equal,
  input  logic             cmp_a_big,
  input  logic             cmp_b_big,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             error,
  output logic [1:0]       dbg_state
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] TRIAL_INIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    IDX_INIT   = IW'(WIDTH - 1);

  sar_state_e       r_state;
  sar_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_trial;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_found;
  logic             r_error;

  logic [WIDTH-1:0] w_next_trial;
  logic             w_last;
  logic             w_hit;
  logic             w_bad;
  logic             w_probing;

  sar_bit_decide #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_bit_decide (
    .trial      (r_trial),
    .idx        (r_idx),
    .cmp_equal  (cmp_equal),
    .cmp_a_big  (cmp_a_big),
    .cmp_b_big  (cmp_b_big),
    .next_trial (w_next_trial),
    .last       (w_last),
    .hit        (w_hit),
    .bad        (w_bad)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        if (w_bad || w_hit) w_state_nxt = S_DONE;
        else if (w_last)    w_state_nxt = S_VERIFY;
      end
      S_VERIFY: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Search datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trial  <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_found  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_trial <= TRIAL_INIT;
            r_idx   <= IDX_INIT;
            r_found <= 1'b0;
            r_error <= 1'b0;
          end
        end
        S_SEARCH: begin
          if (w_bad) begin
            r_error  <= 1'b1;
            r_result <= r_trial;
          end else if (w_hit) begin
            r_found  <= 1'b1;
            r_result <= r_trial;
          end else begin
            r_trial <= w_next_trial;
            if (!w_last) r_idx <= r_idx - 1'b1;
          end
        end
        S_VERIFY: begin
          r_result <= r_trial;
          r_found  <= cmp_equal;
          r_error  <= w_bad;
        end
        default: ;
      endcase
    end
  end

  assign w_probing = (r_state == S_SEARCH) || (r_state == S_VERIFY);
  assign probe     = w_probing ? r_trial : '0;
  assign busy      = w_probing;
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign found     = r_found;
  assign error     = r_error;
  assign dbg_state = r_state;

endmodule : sar_search_ctrl

// File: tb/tb_sar_search_ctrl.sv
module tb_sar_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cmp_equal;
  logic       cmp_a_big;
  logic       cmp_b_big;
  logic [3:0] probe;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       found;
  logic       error;
  logic [1:0] dbg_state;

  logic [3:0] target;
  logic       force_bad;

  int n_checks;
  int n_errors;

  // Responder: 4-bit magnitude comparator with a = target, b = probe.
  // force_bad overlays equal and a_big to create a non-one-hot response.
  assign cmp_equal = (target == probe) | force_bad;
  assign cmp_a_big = (target >  probe) | force_bad;
  assign cmp_b_big = (target <  probe);

  sar_search_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmp_equal (cmp_equal),
    .cmp_a_big (cmp_a_big),
    .cmp_b_big (cmp_b_big),
    .probe     (probe),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .found     (found),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One search: start pulse, then per cycle (sampled mid-cycle) check the
  // probe sequence, count busy cycles and catch the done pulse.
  task automatic run_search(input logic [3:0]  tgt,
                            input logic [19:0] exp_probes,
                            input int          n_probes,
                            input int          exp_lat,
                            input logic [3:0]  exp_res,
                            input logic        exp_found,
                            input logic        exp_err,
                            input int          bad_step,
                            input int          mid_start);
    int         busy_n;
    bit         seen;
    logic [3:0] exp_p;
    logic [19:0] probes;
    busy_n = 0;
    seen   = 0;
    probes = exp_probes;
    target = tgt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      force_bad = (c == bad_step);
      start     = (c == mid_start);
      #1;
      if (done) begin
        seen = 1;
        check("latency", c, exp_lat);
        check("result", result, exp_res);
        check("found", found, exp_found);
        check("error", error, exp_err);
        check("busy_at_done", busy, 0);
      end else begin
        if (busy) busy_n++;
        if (c <= n_probes) begin
          exp_p = probes[19 - 4*(c-1) -: 4];
          check("probe", probe, exp_p);
        end
      end
    end
    force_bad = 1'b0;
    start     = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    check("busy_cycles", busy_n, exp_lat - 1);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("result_hold", result, exp_res);
    check("idle_probe", probe, 0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    start     = 1'b0;
    force_bad = 1'b0;
    target    = 4'b0000;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_probe", probe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_found", found, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;

    // 1: 1011, equal on step 4
    run_search(4'b1011, {4'b1000, 4'b1100, 4'b1010, 4'b1011, 4'b0000}, 4, 5, 4'b1011, 1'b1, 1'b0, 0, 0);
    // 2: 1000, equal on first probe
    run_search(4'b1000, {4'b1000, 16'h0}, 1, 2, 4'b1000, 1'b1, 1'b0, 0, 0);
    // 3: 0000, full search then VERIFY probe 0000
    run_search(4'b0000, {4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000}, 5, 6, 4'b0000, 1'b1, 1'b0, 0, 0);
    // 4: 1111, equal on step 4
    run_search(4'b1111, {4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000}, 4, 5, 4'b1111, 1'b1, 1'b0, 0, 0);
    // 5: non-one-hot response on step 2; step 1 kept bit 3 -> 1100
    run_search(4'b1011, {4'b1000, 4'b1100, 12'h0}, 2, 3, 4'b1100, 1'b0, 1'b1, 2, 0);
    // 5b: a clean search afterwards clears error
    run_search(4'b0101, {4'b1000, 4'b0100, 4'b0110, 4'b0101, 4'b0000}, 4, 5, 4'b0101, 1'b1, 1'b0, 0, 0);

    // 6: reset during step 2 aborts without a done pulse
    target = 4'b0110;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_probe", probe, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_found", found, 0);
    check("abort_error", error, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    // 0110 with a stray start at step 2 that must be ignored
    run_search(4'b0110, {4'b1000, 4'b0100, 4'b0110, 8'h0}, 3, 4, 4'b0110, 1'b1, 1'b0, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_sar_search_ctrl
